ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, log2 of the number of 64-bit words (4096 words).
REQ-002 Parameter RD_LATENCY, default 1, cycles from read request to rvalid; legal range 1..4.
REQ-003 Parameter BASE_ADDR, default 64'h0000_0000_8000_0000, byte address of word 0.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ready  output  1  high when requests are accepted; low during the init sweep.
REQ-007 ren  input  1  read request, sampled every cycle.
REQ-008 raddr  input  64  read byte address.
REQ-009 rdata  output  64  read data, meaningful only while rvalid is high.
REQ-010 rvalid  output  1  one-cycle pulse per accepted read.
REQ-011 rerr  output  1  coincident with rvalid; marks an out-of-range read.
REQ-012 wen  input  1  write request.
REQ-013 waddr  input  64  write byte address.
REQ-014 wdata  input  64  write data.
REQ-015 wmask  input  64  per-bit write enable; bit i high means mem[i] takes wdata[i].
REQ-016 werr  output  1  one-cycle pulse, one cycle after an accepted out-of-range write.

Function
REQ-017 Word index is (addr - BASE_ADDR) >> 3; address bits [2:0] are ignored.
REQ-018 In range means BASE_ADDR <= addr < BASE_ADDR + 8*2^DEPTH_LOG2; the comparison uses the full 64-bit width, with no wrap-around.
REQ-019 States: INIT and SERVE; ready = (state == SERVE).
REQ-020 INIT:
- writes 64'h0 to one word per cycle, index 0 upward;
- moves to SERVE in the cycle after writing index 2^DEPTH_LOG2-1;
- ren and wen are ignored (no rvalid, no werr, no memory change).
REQ-021 SERVE is terminal until reset.
REQ-022 Accepted read: ren high in SERVE.
- rvalid rises exactly RD_LATENCY cycles later, with rdata = word contents at the request edge.
REQ-023 Back-to-back reads are fully pipelined: one request per cycle gives one rvalid per cycle, in request order.
REQ-024 Accepted write: wen high in SERVE and in range.
- updates only the masked bits at that edge;
- wmask all-zero leaves memory unchanged.
REQ-025 Read and write to the same index in the same cycle:
- the read returns the pre-write (old) data;
- the write still takes effect.
REQ-026 A read issued one or more cycles after a write returns the updated data.
REQ-027 Out-of-range read: rvalid still pulses at the normal latency, with rerr=1 and rdata=64'h0.
REQ-028 Out-of-range write: memory unchanged; werr pulses one cycle later.
REQ-029 rdata is 64'h0 whenever rvalid is low.

Reset
REQ-030 While rst is high:
- ready=0, rvalid=0, rerr=0, werr=0, rdata=64'h0;
- all in-flight read pipeline stages are cleared;
- the state is INIT with init index 0.
REQ-031 Reset asserted mid-operation discards outstanding reads (no later rvalid) and restarts the full INIT sweep after deassertion.
REQ-032 After rst deasserts, ready rises after exactly 2^DEPTH_LOG2 clock edges.

Verification
REQ-033 Reset release with DEPTH_LOG2=4 -> ready rises on the 16th edge; a read of BASE_ADDR+0x78 then returns 64'h0.
REQ-034 Write 64'hDEAD_BEEF_0123_4567 to 0x8000_0008 with mask 64'h0000_0000_FFFF_FFFF over 64'hFFFF_FFFF_FFFF_FFFF, then read -> rdata=64'hFFFF_FFFF_0123_4567.
REQ-035 RD_LATENCY=3, reads on 4 consecutive cycles to words 0..3 holding 10,11,12,13 -> rvalid high on 4 consecutive cycles starting 3 cycles after the first request, data 10,11,12,13.
REQ-036 Same-cycle read and write to word 5 (old 64'h1, new 64'h2) -> rvalid carries 64'h1; the next read returns 64'h2.
REQ-037 Read at 0x7FFF_FFF8 and write at BASE+8*2^DEPTH_LOG2 -> rerr=1 with rdata=0; werr pulses; a full memory scan shows no changes.
REQ-038 rst pulsed with two reads in flight (RD_LATENCY=4) -> no rvalid until ready returns, and memory reads back as zero.

Source files
------------

// File: rtl/ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder_if
// Description : Read/write request bus between a requester and ram_responder.
//               The requester drives requests; the responder drives status
//               and read responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_responder_if;
  logic        ready;
  logic        ren;
  logic [63:0] raddr;
  logic [63:0] rdata;
  logic        rvalid;
  logic        rerr;
  logic        wen;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [63:0] wmask;
  logic        werr;

  // Requester side
  modport master (
    input  ready, rdata, rvalid, rerr, werr,
    output ren, raddr, wen, waddr, wdata, wmask
  );

  // Responder side
  modport slave (
    input  ren, raddr, wen, waddr, wdata, wmask,
    output ready, rdata, rvalid, rerr, werr
  );
endinterface
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder
// Description : 64-bit word RAM mapped at BASE_ADDR. Zero-fills itself after
//               reset, then serves pipelined reads with fixed latency and
//               bit-masked writes; flags accesses outside the mapped window.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          RD_LATENCY = 1,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ram_responder_if.slave bus
);

  localparam int                    c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [63:0]           c_SPAN  = 64'(c_DEPTH) << 3;
  localparam logic [DEPTH_LOG2-1:0] c_LAST  = '1;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_init_idx;
  logic [DEPTH_LOG2-1:0] w_init_idx_nxt;

  logic [63:0] r_mem [c_DEPTH];

  logic        r_vld [RD_LATENCY];
  logic        r_err [RD_LATENCY];
  logic [63:0] r_dat [RD_LATENCY];
  logic        r_werr;

  // Address decode: offsets are taken over the full 64 bits, so addresses
  // below BASE_ADDR fail the lower-bound test rather than wrapping in.
  logic [63:0]           w_roff;
  logic [63:0]           w_woff;
  logic                  w_rin;
  logic                  w_win;
  logic [DEPTH_LOG2-1:0] w_ridx;
  logic [DEPTH_LOG2-1:0] w_widx;
  logic                  w_serve;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_wr_oor;

  assign w_roff   = bus.raddr - BASE_ADDR;
  assign w_woff   = bus.waddr - BASE_ADDR;
  assign w_rin    = (bus.raddr >= BASE_ADDR) && (w_roff < c_SPAN);
  assign w_win    = (bus.waddr >= BASE_ADDR) && (w_woff < c_SPAN);
  assign w_ridx   = w_roff[DEPTH_LOG2+2:3];
  assign w_widx   = w_woff[DEPTH_LOG2+2:3];
  assign w_serve  = (r_state == ST_SERVE);
  assign w_rd_acc = bus.ren && w_serve;
  assign w_wr_acc = bus.wen && w_serve && w_win;
  assign w_wr_oor = bus.wen && w_serve && !w_win;

  // State register and init-sweep index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  // Next state: sweep every word once, then serve until reset
  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    if (r_state == ST_INIT) begin
      w_init_idx_nxt = r_init_idx + 1'b1;
      if (r_init_idx == c_LAST) begin
        w_state_nxt = ST_SERVE;
      end
    end
  end

  // Storage: zero-fill during the sweep, otherwise bit-masked writes
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_idx] <= '0;
    end else if (w_wr_acc) begin
      r_mem[w_widx] <= (r_mem[w_widx] & ~bus.wmask) | (bus.wdata & bus.wmask);
    end
  end

  // Read pipeline: data captured at the request edge, so a same-cycle
  // write to the same word is not visible to that read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      r_err[0] <= w_rd_acc && !w_rin;
      r_dat[0] <= (w_rd_acc && w_rin) ? r_mem[w_ridx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  // Out-of-range write flag, one cycle after the offending request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_werr <= 1'b0;
    end else begin
      r_werr <= w_wr_oor;
    end
  end

  assign bus.ready  = w_serve;
  assign bus.rvalid = r_vld[RD_LATENCY-1];
  assign bus.rerr   = r_vld[RD_LATENCY-1] && r_err[RD_LATENCY-1];
  assign bus.rdata  = r_vld[RD_LATENCY-1] ? r_dat[RD_LATENCY-1] : '0;
  assign bus.werr   = r_werr;

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_responder
// Description : Directed bench for ram_responder (16 words, read latency 3).
//               Stimulus pushes expected responses; a negedge monitor pops
//               and compares them against rvalid/rerr/rdata and werr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

  localparam int          DL   = 4;
  localparam int          L    = 3;
  localparam int          NW   = 16;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_responder_if bus();

  ram_responder #(
    .DEPTH_LOG2 (DL),
    .RD_LATENCY (L),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [63:0] data;
  } rd_exp_t;

  rd_exp_t     rq[$];
  int          wq[$];
  logic [63:0] model [NW];

  // Count rising edges; expectations are keyed to this count
  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: pop read expectations when due, flag unexpected responses
  always @(negedge clk) begin
    rd_exp_t e;
    logic    wexp;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      chk("rd_rvalid", {63'd0, bus.rvalid}, 64'd1);
      chk("rd_rerr",   {63'd0, bus.rerr},   {63'd0, e.err});
      chk("rd_rdata",  bus.rdata,           e.data);
    end else if (bus.rvalid) begin
      chk("rd_spurious_rvalid", {63'd0, bus.rvalid}, 64'd0);
    end else begin
      chk("rdata_idle", bus.rdata, 64'd0);
    end
    wexp = (wq.size() > 0 && wq[0] == cyc);
    if (wexp) void'(wq.pop_front());
    if (wexp || bus.werr) chk("werr", {63'd0, bus.werr}, {63'd0, wexp});
  end

  task automatic tick();
    @(negedge clk);
    bus.ren = 1'b0;
    bus.wen = 1'b0;
  endtask

  task automatic drive_rd(input logic [63:0] a, input logic err, input logic [63:0] d);
    bus.ren   = 1'b1;
    bus.raddr = a;
    rq.push_back('{cyc + L, err, d});
  endtask

  task automatic drive_wr(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
    int idx;
    bus.wen   = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    bus.wmask = m;
    if (a >= BASE && a < BASE + 64'(8 * NW)) begin
      idx = int'((a - BASE) >> 3);
      model[idx] = (model[idx] & ~m) | (d & m);
    end else begin
      wq.push_back(cyc + 1);
    end
  endtask

  task automatic rd(input logic [63:0] a, input logic err, input logic [63:0] d);
    drive_rd(a, err, d);
    tick();
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
    drive_wr(a, d, m);
    tick();
  endtask

  task automatic scan();
    for (int i = 0; i < NW; i++) rd(BASE + 64'(8 * i), 1'b0, model[i]);
  endtask

  task automatic drain();
    repeat (L + 2) @(negedge clk);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n), 64'(NW));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  {63'd0, bus.ready},  64'd0);
    chk({tag, "_rvalid"}, {63'd0, bus.rvalid}, 64'd0);
    chk({tag, "_rerr"},   {63'd0, bus.rerr},   64'd0);
    chk({tag, "_werr"},   {63'd0, bus.werr},   64'd0);
    chk({tag, "_rdata"},  bus.rdata,           64'd0);
  endtask

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ren   = 1'b0;
    bus.raddr = '0;
    bus.wen   = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.wmask = '0;
    for (int i = 0; i < NW; i++) model[i] = '0;

    // Reset state, then requests held high through the sweep must be ignored
    @(negedge clk);
    chk_reset_outputs("rst");
    bus.ren   = 1'b1;
    bus.raddr = BASE;
    bus.wen   = 1'b1;
    bus.waddr = BASE;
    bus.wdata = '1;
    bus.wmask = '1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_edges_initial");
    bus.ren = 1'b0;
    bus.wen = 1'b0;

    // Top word after init reads zero
    rd(BASE + 64'h78, 1'b0, 64'h0);

    // Masked write over all-ones
    wr(BASE + 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(BASE + 64'h8, 64'hDEAD_BEEF_0123_4567, 64'h0000_0000_FFFF_FFFF);
    rd(BASE + 64'h8, 1'b0, 64'hFFFF_FFFF_0123_4567);

    // Back-to-back pipelined reads of words 0..3
    wr(BASE + 64'h00, 64'd10, '1);
    wr(BASE + 64'h08, 64'd11, '1);
    wr(BASE + 64'h10, 64'd12, '1);
    wr(BASE + 64'h18, 64'd13, '1);
    rd(BASE + 64'h00, 1'b0, 64'd10);
    rd(BASE + 64'h08, 1'b0, 64'd11);
    rd(BASE + 64'h10, 1'b0, 64'd12);
    rd(BASE + 64'h18, 1'b0, 64'd13);

    // Same-cycle read and write of word 5 returns old data
    wr(BASE + 64'h28, 64'h1, '1);
    drive_rd(BASE + 64'h28, 1'b0, 64'h1);
    drive_wr(BASE + 64'h28, 64'h2, '1);
    tick();
    rd(BASE + 64'h28, 1'b0, 64'h2);

    // Zero mask leaves the word untouched
    wr(BASE + 64'h28, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0);
    rd(BASE + 64'h28, 1'b0, 64'h2);

    // Partial byte mask; low address bits ignored on the read
    wr(BASE + 64'h38, 64'h1234_5678_9ABC_DEF0, 64'hFF00_FF00_FF00_FF00);
    rd(BASE + 64'h3D, 1'b0, 64'h1200_5600_9A00_DE00);

    // Out-of-range reads and writes on both sides of the window
    rd(64'h0000_0000_7FFF_FFF8, 1'b1, 64'h0);
    wr(BASE + 64'(8 * NW), '1, '1);
    rd(BASE + 64'(8 * NW), 1'b1, 64'h0);
    rd(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'h0);
    wr(64'h0, '1, '1);
    wr(64'hFFFF_FFFF_FFFF_FFF8, '1, '1);
    scan();
    drain();
    chk("rq_drained_a", 64'(rq.size()), 64'd0);
    chk("wq_drained_a", 64'(wq.size()), 64'd0);

    // Reset with two reads in flight: both discarded, sweep restarts
    drive_rd(BASE + 64'h00, 1'b0, 64'd10);
    tick();
    drive_rd(BASE + 64'h08, 1'b0, 64'd11);
    tick();
    #1;
    rst = 1'b1;
    rq.delete();
    for (int i = 0; i < NW; i++) model[i] = '0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_edges_after_midrst");
    scan();
    drain();
    chk("rq_drained_b", 64'(rq.size()), 64'd0);
    chk("wq_drained_b", 64'(wq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
